// File: rtl/pacman_tile_renderer_pkg.sv
// Shared playfield geometry, colours and pixel-flag layout for the tile renderer,
// the player controller and the tilemap RAM.
package pacman_tile_renderer_pkg;

  localparam int TILE_SHIFT = 3;
  localparam int MAP_COLS   = 28;
  localparam int MAP_ROWS   = 31;
  localparam int ADDR_W     = 10;
  localparam int SPRITE_PX  = 8;

  localparam logic [11:0] COL_BLACK  = 12'h000;
  localparam logic [11:0] COL_WALL   = 12'h00F;
  localparam logic [11:0] COL_DOT    = 12'hFFF;
  localparam logic [11:0] COL_PLAYER = 12'hFF0;

  typedef logic [ADDR_W-1:0] tile_idx_t;

  typedef struct packed {
    logic                  de;
    logic                  in_map;
    logic                  hit;
    logic [TILE_SHIFT-1:0] sub_x;
    logic [TILE_SHIFT-1:0] sub_y;
  } pixel_flags_t;

  // Dots are drawn as a 2x2 block in the centre of the tile.
  function automatic logic dot_centre(input logic [TILE_SHIFT-1:0] sub);
    return (sub == TILE_SHIFT'(3)) || (sub == TILE_SHIFT'(4));
  endfunction

endpackage

// File: rtl/pacman_tile_renderer_delay_line.sv
// Fixed-depth shift register with synchronous reset to a configurable vector,
// used to carry sync/enable and per-pixel flags alongside the pipeline.
module pixel_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= RST_VAL;
    end else begin
      stages[0] <= d;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/pacman_tile_renderer.sv
// Per-pixel tilemap fetch plus player sprite overlay; emits registered RGB with
// de/hs/vs delayed to match the three-cycle pipeline.
module pacman_tile_renderer
  import pacman_tile_renderer_pkg::*;
#(
  parameter int   PX_W      = 10,
  parameter int   MAP_X0    = 208,
  parameter int   MAP_Y0    = 116,
  parameter logic SYNC_IDLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PX_W-1:0]   pix_x,
  input  logic [PX_W-1:0]   pix_y,
  input  logic              de_in,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              frame_start,
  input  logic [PX_W-1:0]   player_x,
  input  logic [PX_W-1:0]   player_y,
  output logic              tile_rd_en,
  output logic [ADDR_W-1:0] tile_rd_addr,
  input  logic              tile_wall,
  input  logic              tile_dot,
  output logic [11:0]       rgb,
  output logic              de_out,
  output logic              hs_out,
  output logic              vs_out
);

  localparam int CELL_W = PX_W - TILE_SHIFT;

  logic [PX_W-1:0]   player_px, player_py;
  logic [PX_W:0]     dx, dy, hx, hy;
  logic [CELL_W-1:0] col, row;
  logic              in_map, hit;
  tile_idx_t         addr_next;
  pixel_flags_t      flags_in, flags_s1;
  logic [$bits(pixel_flags_t)-1:0] flags_s1_bits;
  logic [2:0]        sync_q;
  logic [11:0]       rgb_next;
  logic              wall_ok, dot_ok;

  // Player position is sampled once per frame so the sprite never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      player_px <= '1;
      player_py <= '1;
    end else if (frame_start) begin
      player_px <= player_x;
      player_py <= player_y;
    end
  end

  assign dx  = {1'b0, pix_x} - (PX_W+1)'(MAP_X0);
  assign dy  = {1'b0, pix_y} - (PX_W+1)'(MAP_Y0);
  assign col = dx[PX_W-1:TILE_SHIFT];
  assign row = dy[PX_W-1:TILE_SHIFT];
  assign in_map = !dx[PX_W] && !dy[PX_W] &&
                  (col < CELL_W'(MAP_COLS)) && (row < CELL_W'(MAP_ROWS));
  assign addr_next = in_map ? (ADDR_W'(row) * ADDR_W'(MAP_COLS) + ADDR_W'(col)) : '0;

  // The extra top bit is a borrow, so a sprite near the right edge cannot wrap to x=0.
  assign hx  = {1'b0, pix_x} - {1'b0, player_px};
  assign hy  = {1'b0, pix_y} - {1'b0, player_py};
  assign hit = !hx[PX_W] && !hy[PX_W] &&
               (hx[PX_W-1:0] < PX_W'(SPRITE_PX)) && (hy[PX_W-1:0] < PX_W'(SPRITE_PX));

  always_ff @(posedge clk) begin
    if (rst) begin
      tile_rd_en   <= 1'b0;
      tile_rd_addr <= '0;
    end else begin
      tile_rd_en   <= in_map & de_in;
      tile_rd_addr <= addr_next;
    end
  end

  assign flags_in = '{de: de_in, in_map: in_map, hit: hit,
                      sub_x: dx[TILE_SHIFT-1:0], sub_y: dy[TILE_SHIFT-1:0]};

  pixel_delay_line #(
    .WIDTH   ($bits(pixel_flags_t)),
    .DEPTH   (2),
    .RST_VAL ('0)
  ) u_flag_dly (
    .clk (clk),
    .rst (rst),
    .d   (flags_in),
    .q   (flags_s1_bits)
  );

  assign flags_s1 = pixel_flags_t'(flags_s1_bits);

  pixel_delay_line #(
    .WIDTH   (3),
    .DEPTH   (3),
    .RST_VAL ({1'b0, SYNC_IDLE, SYNC_IDLE})
  ) u_sync_dly (
    .clk (clk),
    .rst (rst),
    .d   ({de_in, hs_in, vs_in}),
    .q   (sync_q)
  );

  assign {de_out, hs_out, vs_out} = sync_q;

  // RAM data is the output of the RAM's own read register, so it lines up with
  // the second flag stage and feeds the colour mux directly.
  assign wall_ok = tile_wall & flags_s1.de & flags_s1.in_map;
  assign dot_ok  = tile_dot  & flags_s1.de & flags_s1.in_map;

  always_comb begin
    rgb_next = COL_BLACK;
    if (!flags_s1.de)
      rgb_next = COL_BLACK;
    else if (flags_s1.hit)
      rgb_next = COL_PLAYER;
    else if (!flags_s1.in_map)
      rgb_next = COL_BLACK;
    else if (wall_ok)
      rgb_next = COL_WALL;
    else if (dot_ok && dot_centre(flags_s1.sub_x) && dot_centre(flags_s1.sub_y))
      rgb_next = COL_DOT;
  end

  always_ff @(posedge clk) begin
    if (rst) rgb <= COL_BLACK;
    else     rgb <= rgb_next;
  end

endmodule

// File: tb/tb_pacman_tile_renderer.sv
// Scoreboard bench for pacman_tile_renderer: expected pixels are queued when
// driven and compared three cycles later; a behavioural RAM answers reads.
module tb_pacman_tile_renderer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  pix_x = '0, pix_y = '0;
  logic        de_in = 1'b0, hs_in = 1'b1, vs_in = 1'b1, frame_start = 1'b0;
  logic [9:0]  player_x = '0, player_y = '0;
  logic        tile_rd_en;
  logic [9:0]  tile_rd_addr;
  logic        tile_wall = 1'b0, tile_dot = 1'b0;
  logic [11:0] rgb;
  logic        de_out, hs_out, vs_out;

  typedef struct {
    logic [11:0] rgb;
    logic        de, hs, vs, rd_en;
    logic [9:0]  addr;
  } exp_t;

  exp_t sb[$];
  logic wall_mem [1024];
  logic dot_mem  [1024];
  int   model_px = 1023, model_py = 1023;
  int   checks = 0, failures = 0;
  bit   just_reset = 1'b0;

  pacman_tile_renderer dut (
    .clk          (clk),
    .rst          (rst),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .de_in        (de_in),
    .hs_in        (hs_in),
    .vs_in        (vs_in),
    .frame_start  (frame_start),
    .player_x     (player_x),
    .player_y     (player_y),
    .tile_rd_en   (tile_rd_en),
    .tile_rd_addr (tile_rd_addr),
    .tile_wall    (tile_wall),
    .tile_dot     (tile_dot),
    .rgb          (rgb),
    .de_out       (de_out),
    .hs_out       (hs_out),
    .vs_out       (vs_out)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM; returns junk when not strobed so ungated use shows up.
  always @(posedge clk) begin
    if (tile_rd_en) begin
      tile_wall <= wall_mem[tile_rd_addr];
      tile_dot  <= dot_mem[tile_rd_addr];
    end else begin
      tile_wall <= 1'($urandom);
      tile_dot  <= 1'($urandom);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int x, input int y, input logic de, input logic hs, input logic vs);
    exp_t e;
    bit   in_map, hit, centre;
    int   col, row, a;
    in_map = (x >= 208) && (x < 432) && (y >= 116) && (y < 364);
    col    = (x - 208) / 8;
    row    = (y - 116) / 8;
    a      = in_map ? row * 28 + col : 0;
    hit    = (x >= model_px) && (x < model_px + 8) && (y >= model_py) && (y < model_py + 8);
    centre = in_map && ((x - 208) % 8 inside {3, 4}) && ((y - 116) % 8 inside {3, 4});
    e.de = de; e.hs = hs; e.vs = vs;
    e.rd_en = in_map && de;
    e.addr  = 10'(a);
    if (!de)                               e.rgb = 12'h000;
    else if (hit)                          e.rgb = 12'hFF0;
    else if (!in_map)                      e.rgb = 12'h000;
    else if (wall_mem[a])                  e.rgb = 12'h00F;
    else if (dot_mem[a] && centre)         e.rgb = 12'hFFF;
    else                                   e.rgb = 12'h000;
    return e;
  endfunction

  task automatic applyStimulus(input int x, input int y, input logic de, input logic hs,
                               input logic vs, input logic fs);
    exp_t e;
    @(negedge clk);
    if (just_reset) begin
      checkOutput("rst_rgb", 32'(rgb), 32'h000);
      checkOutput("rst_de", 32'(de_out), 32'd0);
      checkOutput("rst_hs", 32'(hs_out), 32'd1);
      checkOutput("rst_vs", 32'(vs_out), 32'd1);
      checkOutput("rst_rd_en", 32'(tile_rd_en), 32'd0);
      checkOutput("rst_rd_addr", 32'(tile_rd_addr), 32'd0);
      just_reset = 1'b0;
    end
    if (sb.size() > 0) begin
      checkOutput("rd_en", 32'(tile_rd_en), 32'(sb[$].rd_en));
      checkOutput("rd_addr", 32'(tile_rd_addr), 32'(sb[$].addr));
    end
    if (sb.size() == 3) begin
      e = sb.pop_front();
      checkOutput("rgb", 32'(rgb), 32'(e.rgb));
      checkOutput("de_out", 32'(de_out), 32'(e.de));
      checkOutput("hs_out", 32'(hs_out), 32'(e.hs));
      checkOutput("vs_out", 32'(vs_out), 32'(e.vs));
    end
    rst = 1'b0;
    pix_x = 10'(x); pix_y = 10'(y);
    de_in = de; hs_in = hs; vs_in = vs; frame_start = fs;
    sb.push_back(model(x, y, de, hs, vs));
    if (fs) begin
      model_px = int'(player_x);
      model_py = int'(player_y);
    end
  endtask

  task automatic applyReset(input logic fs);
    @(negedge clk);
    rst = 1'b1;
    frame_start = fs;
    pix_x = 10'($urandom_range(431, 208));
    pix_y = 10'($urandom_range(363, 116));
    de_in = 1'b1; hs_in = 1'b0; vs_in = 1'b0;
    sb.delete();
    model_px = 1023;
    model_py = 1023;
    just_reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      wall_mem[i] = ($urandom_range(3, 0) == 0);
      dot_mem[i]  = 1'($urandom);
    end
    wall_mem[61] = 1'b0; dot_mem[61] = 1'b1;
    wall_mem[291] = 1'b1; wall_mem[292] = 1'b1;

    repeat (3) @(negedge clk);
    applyReset(1'b0);

    applyStimulus(251, 136, 1, 1, 1, 0);
    applyStimulus(207, 116, 1, 1, 1, 0);
    applyStimulus(432, 200, 1, 1, 1, 0);
    applyStimulus(431, 363, 1, 1, 1, 0);
    applyStimulus(431, 364, 1, 1, 1, 0);
    applyStimulus(208, 116, 1, 0, 1, 0);
    applyStimulus(251, 136, 0, 1, 0, 0);

    player_x = 300; player_y = 200;
    applyStimulus(0, 0, 0, 1, 1, 1);
    applyStimulus(300, 200, 1, 1, 1, 0);
    applyStimulus(308, 200, 1, 1, 1, 0);
    applyStimulus(307, 207, 1, 1, 1, 0);

    player_x = 100;
    applyStimulus(100, 200, 1, 1, 1, 0);
    applyStimulus(300, 200, 1, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 1, 1);
    applyStimulus(100, 200, 1, 1, 1, 0);

    player_x = 1020; player_y = 200;
    applyStimulus(0, 0, 0, 1, 1, 1);
    applyStimulus(2, 200, 1, 1, 1, 0);
    applyStimulus(1022, 200, 1, 1, 1, 0);
    applyStimulus(1023, 207, 1, 1, 1, 0);

    for (int n = 0; n < 300; n++) begin
      logic fs;
      fs = ($urandom_range(49, 0) == 0);
      if (fs) begin
        player_x = 10'($urandom_range(440, 190));
        player_y = 10'($urandom_range(370, 110));
      end
      applyStimulus($urandom_range(450, 190), $urandom_range(380, 100),
                    1'($urandom), 1'($urandom), 1'($urandom), fs);
      if (n == 150) applyReset(1'b0);
    end

    player_x = 300; player_y = 200;
    applyStimulus(300, 200, 1, 1, 1, 0);
    applyReset(1'b1);
    applyStimulus(300, 200, 1, 1, 1, 0);
    applyStimulus(301, 201, 1, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 1, 1);
    applyStimulus(300, 200, 1, 1, 1, 0);
    repeat (4) applyStimulus(0, 0, 0, 1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
